// File: rtl/me_pkg.sv
// Shared motion-estimation definitions.
// Holds the search FSM state type and the width helpers. The SAD/MV widths
// are derived here so that the PE array and the SAD search stay consistent.
package me_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } me_state_e;

  // Width of the sum of n_pe unsigned 8-bit lanes.
  function automatic int lane_sum_w(input int n_pe);
    return 8 + $clog2(n_pe);
  endfunction

  // Width holding 255 * n_pe * acc_len without overflow.
  function automatic int sad_w(input int n_pe, input int acc_len);
    return 8 + $clog2(n_pe * acc_len);
  endfunction

  // Width of one motion-vector component for sr candidates per axis.
  function automatic int mv_w(input int sr);
    return (sr > 1) ? $clog2(sr) : 1;
  endfunction

endpackage

// File: rtl/ad_sum_tree.sv
// Stage 1 of the SAD search: adds N_PE unsigned 8-bit lanes and registers
// the sum together with a valid bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush of the output register and valid
//   in_valid   : in_vec carries a beat
//   in_vec     : lane i in bits [8i+7:8i]
//   sum        : registered lane sum
//   sum_valid  : sum carries a beat
module ad_sum_tree
  import me_pkg::*;
#(
  parameter  int N_PE  = 16,
  localparam int SUM_W = lane_sum_w(N_PE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [8*N_PE-1:0] in_vec,
  output logic [SUM_W-1:0]  sum,
  output logic              sum_valid
);

  logic [SUM_W-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < N_PE; i++) begin
      sum_c = sum_c + SUM_W'(in_vec[8*i +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      sum_valid <= 1'b0;
    end else if (clr) begin
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= in_valid;
      if (in_valid) sum <= sum_c;
    end
  end

endmodule

// File: rtl/sad_min_search.sv
// Per-candidate SAD accumulation and minimum search over an SR x SR range.
// Beats are captured (stage 0), summed across lanes (stage 1, ad_sum_tree),
// then accumulated and compared against the running minimum (stage 2).
//   clk, rst_n          : clock, asynchronous active-low reset
//   abort               : only with SAD_MIN_ABORT_EN; cancels a search
//   start               : begin a search (honoured in IDLE, not busy)
//   ad_valid, ad_vec    : one beat of N_PE unsigned 8-bit absolute differences
//   busy                : search in progress
//   done                : one-cycle pulse when best_* are final
//   best_sad            : minimum SAD, all ones until a candidate completes
//   best_mvx, best_mvy  : raster position of the winning candidate
// Optional feature macro: SAD_MIN_ABORT_EN.
module sad_min_search
  import me_pkg::*;
#(
  parameter  int N_PE    = 16,
  parameter  int ACC_LEN = 16,
  parameter  int SR      = 32,
  localparam int SAD_W   = sad_w(N_PE, ACC_LEN),
  localparam int MV_W    = mv_w(SR)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SAD_MIN_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic              ad_valid,
  input  logic [8*N_PE-1:0] ad_vec,
  output logic              busy,
  output logic              done,
  output logic [SAD_W-1:0]  best_sad,
  output logic [MV_W-1:0]   best_mvx,
  output logic [MV_W-1:0]   best_mvy
);

  localparam int TOT    = SR * SR * ACC_LEN;
  localparam int CNT_W  = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int BEAT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int SUM_W  = lane_sum_w(N_PE);

  me_state_e state, state_nxt;

  logic              accept, go, abort_go, last_in;
  logic [CNT_W-1:0]  in_cnt;
  logic              beat_v;
  logic [8*N_PE-1:0] beat_vec;
  logic [SUM_W-1:0]  sum;
  logic              sum_valid;
  logic [SAD_W-1:0]  acc, cand;
  logic [BEAT_W-1:0] beat_cnt;
  logic [MV_W-1:0]   mvx, mvy;
  logic              cand_end, search_end;

`ifdef SAD_MIN_ABORT_EN
  assign abort_go = abort && (state != IDLE);
`else
  assign abort_go = 1'b0;
`endif

  assign last_in = (in_cnt == CNT_W'(TOT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // busy covers the tail of the pipeline after the FSM has returned to IDLE,
  // so a new start cannot overlap the last compare.
  always_comb begin
    state_nxt = state;
    if (abort_go) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !busy) state_nxt = RUN;
        RUN:     if (ad_valid && last_in) state_nxt = DRAIN;
        DRAIN:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    accept = 1'b0;
    go     = 1'b0;
    case (state)
      IDLE:    go     = start && !busy;
      RUN:     accept = ad_valid && !abort_go;
      default: ;
    endcase
  end

  // Stage 0: beat capture and input-side beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_v   <= 1'b0;
      beat_vec <= '0;
      in_cnt   <= '0;
    end else if (abort_go || go) begin
      beat_v   <= 1'b0;
      beat_vec <= '0;
      in_cnt   <= '0;
    end else begin
      beat_v <= accept;
      if (accept) begin
        beat_vec <= ad_vec;
        in_cnt   <= last_in ? '0 : in_cnt + 1'b1;
      end
    end
  end

  ad_sum_tree #(.N_PE(N_PE)) u_sum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort_go),
    .in_valid  (beat_v),
    .in_vec    (beat_vec),
    .sum       (sum),
    .sum_valid (sum_valid)
  );

  // Stage 2: accumulate, compare, advance the raster position.
  assign cand       = acc + SAD_W'(sum);
  assign cand_end   = sum_valid && (beat_cnt == BEAT_W'(ACC_LEN - 1));
  assign search_end = cand_end && (mvx == MV_W'(SR - 1)) && (mvy == MV_W'(SR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
      mvx      <= '0;
      mvy      <= '0;
      best_sad <= '1;
      best_mvx <= '0;
      best_mvy <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_go || go) begin
        acc      <= '0;
        beat_cnt <= '0;
        mvx      <= '0;
        mvy      <= '0;
        best_sad <= '1;
        best_mvx <= '0;
        best_mvy <= '0;
        busy     <= go;
      end else if (sum_valid) begin
        if (cand_end) begin
          acc      <= '0;
          beat_cnt <= '0;
          if (cand < best_sad) begin
            best_sad <= cand;
            best_mvx <= mvx;
            best_mvy <= mvy;
          end
          if (search_end) begin
            mvx  <= '0;
            mvy  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
          end else if (mvx == MV_W'(SR - 1)) begin
            mvx <= '0;
            mvy <= mvy + 1'b1;
          end else begin
            mvx <= mvx + 1'b1;
          end
        end else begin
          acc      <= cand;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_min_search.sv
// Self-checking bench for sad_min_search with N_PE=4, ACC_LEN=2, SR=2.
module tb_sad_min_search;

  localparam int N_PE    = 4;
  localparam int ACC_LEN = 2;
  localparam int SR      = 2;
  localparam int NCAND   = SR * SR;
  localparam int TOT     = NCAND * ACC_LEN;
  localparam int SAD_W   = 11;
  localparam int MV_W    = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              ad_valid;
  logic [8*N_PE-1:0] ad_vec;
  logic              busy, done;
  logic [SAD_W-1:0]  best_sad;
  logic [MV_W-1:0]   best_mvx, best_mvy;
`ifdef SAD_MIN_ABORT_EN
  logic              abort;
`endif

  always #5 clk = ~clk;

  sad_min_search #(.N_PE(N_PE), .ACC_LEN(ACC_LEN), .SR(SR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SAD_MIN_ABORT_EN
    .abort    (abort),
`endif
    .start    (start),
    .ad_valid (ad_valid),
    .ad_vec   (ad_vec),
    .busy     (busy),
    .done     (done),
    .best_sad (best_sad),
    .best_mvx (best_mvx),
    .best_mvy (best_mvy)
  );

  int          beats [TOT][N_PE];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_beat(input int b);
    for (int l = 0; l < N_PE; l++) ad_vec[8*l +: 8] = 8'(beats[b][l]);
  endtask

  task automatic fill_random();
    for (int b = 0; b < TOT; b++)
      for (int l = 0; l < N_PE; l++) beats[b][l] = int'($urandom_range(0, 255));
  endtask

  task automatic fill_const(input int v);
    for (int b = 0; b < TOT; b++)
      for (int l = 0; l < N_PE; l++) beats[b][l] = v;
  endtask

  // Reference: SAD of candidate c is the plain sum of its ACC_LEN*N_PE values;
  // the winner is the first candidate (raster order) holding the minimum.
  task automatic model(output int exp_sad, output int exp_x, output int exp_y);
    int s, idx;
    exp_sad = 0;
    idx     = 0;
    for (int c = 0; c < NCAND; c++) begin
      s = 0;
      for (int k = 0; k < ACC_LEN; k++)
        for (int l = 0; l < N_PE; l++) s += beats[c*ACC_LEN + k][l];
      if (c == 0 || s < exp_sad) begin
        exp_sad = s;
        idx     = c;
      end
    end
    exp_x = idx % SR;
    exp_y = idx / SR;
  endtask

  task automatic run_search(input string name, input bit gaps, input bit poke_start);
    int exp_sad, exp_x, exp_y, cyc;
    model(exp_sad, exp_x, exp_y);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({name, "_busy_start"}, 32'(busy), 1);
    for (int b = 0; b < TOT; b++) begin
      if (gaps && b > 0) begin
        ad_valid = 1'b0;
        ad_vec   = $urandom;
        repeat (3) @(negedge clk);
      end
      if (poke_start && b == TOT / 2) start = 1'b1;
      drive_beat(b);
      ad_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    ad_valid = 1'b0;
    ad_vec   = $urandom;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_latency"}, 32'(cyc), 2);
    check({name, "_sad"}, 32'(best_sad), 32'(exp_sad));
    check({name, "_mvx"}, 32'(best_mvx), 32'(exp_x));
    check({name, "_mvy"}, 32'(best_mvy), 32'(exp_y));
    check({name, "_busy_end"}, 32'(busy), 0);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 0);
    check({name, "_sad_hold"}, 32'(best_sad), 32'(exp_sad));
  endtask

  initial begin
    int hold_sad;
    rst_n    = 1'b0;
    start    = 1'b0;
    ad_valid = 1'b0;
    ad_vec   = '0;
`ifdef SAD_MIN_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_sad", 32'(best_sad), 32'h7FF);
    check("rst_mvx", 32'(best_mvx), 0);
    check("rst_mvy", 32'(best_mvy), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp: candidates 0..2 all ones, candidate 3 zeros.
    fill_const(1);
    for (int b = 3 * ACC_LEN; b < TOT; b++)
      for (int l = 0; l < N_PE; l++) beats[b][l] = 0;
    run_search("ramp", 1'b0, 1'b0);

    // Tie: SADs 10, 5, 5, 7 -> earlier 5 wins.
    fill_const(0);
    beats[0 * ACC_LEN][0] = 10;
    beats[1 * ACC_LEN][1] = 5;
    beats[2 * ACC_LEN][2] = 5;
    beats[3 * ACC_LEN][3] = 7;
    run_search("tie", 1'b0, 1'b0);

    fill_const(255);
    run_search("full", 1'b0, 1'b0);

    // Same random data with and without gaps; start poked mid-run.
    fill_random();
    run_search("rand_nogap", 1'b0, 1'b0);
    run_search("rand_gap", 1'b1, 1'b1);

    // Beats while idle must not disturb the held result.
    hold_sad = int'(best_sad);
    for (int i = 0; i < 4; i++) begin
      ad_vec   = $urandom;
      ad_valid = 1'b1;
      @(negedge clk);
    end
    ad_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_beats_sad", 32'(best_sad), 32'(hold_sad));
    check("idle_beats_busy", 32'(busy), 0);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_search($sformatf("rand%0d", r), 1'(r & 1), 1'b0);
    end

    // Reset in the middle of a candidate.
    fill_random();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive_beat(b);
      ad_valid = 1'b1;
      @(negedge clk);
    end
    ad_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_sad", 32'(best_sad), 32'h7FF);
    check("midrst_mvx", 32'(best_mvx), 0);
    check("midrst_mvy", 32'(best_mvy), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_search("after_rst", 1'b0, 1'b0);

`ifdef SAD_MIN_ABORT_EN
    begin
      int seen_done;
      fill_random();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int b = 0; b < 3; b++) begin
        drive_beat(b);
        ad_valid = 1'b1;
        @(negedge clk);
      end
      ad_valid = 1'b0;
      abort    = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_sad", 32'(best_sad), 32'h7FF);
      check("abort_mvx", 32'(best_mvx), 0);
      check("abort_mvy", 32'(best_mvy), 0);
      seen_done = 0;
      for (int i = 0; i < 8; i++) begin
        if (done === 1'b1) seen_done = 1;
        @(negedge clk);
      end
      check("abort_no_done", 32'(seen_done), 0);
      run_search("after_abort", 1'b0, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sad_min_search.md
# sad_min_search

Accumulates the absolute differences from one row of N_PE processing elements into a per-candidate SAD and tracks the minimum-SAD candidate over a full search range. The block returns the winning motion vector and its SAD. It sits directly downstream of the PE array: each PE's `ad` output feeds one lane of `ad_vec`. A beat is one cycle's worth of `ad` values from all lanes.

## Interface
- `N_PE`, 16: number of PE lanes summed per beat.
- `ACC_LEN`, 16: beats per candidate (block rows).
- `SR`, 32: candidates per axis; the search covers SR×SR candidates.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new search. Honoured only in IDLE.
- `ad_valid` in 1: `ad_vec` carries a valid beat.
- `ad_vec` in 8*N_PE: lane i is bits [8i+7:8i], unsigned.
- `busy` out 1: search in progress.
- `done` out 1: one-cycle pulse when the search is complete.
- `best_sad` out SAD_W: minimum SAD found, where SAD_W = 8 + clog2(N_PE*ACC_LEN).
- `best_mvx` out MV_W: x index of the winning candidate, where MV_W = clog2(SR).
- `best_mvy` out MV_W: y index of the winning candidate.

## Operation
- **Reset values:**
  - `busy`=0, `done`=0.
  - `best_sad` = all ones.
  - `best_mvx` = `best_mvy` = 0.
  - All counters and pipeline registers = 0.
  - State = IDLE.
- **States:** IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`. This clears the counters and accumulator and loads `best_sad` = all ones and MV = 0.
  - RUN→DRAIN on acceptance of the final beat of the final candidate.
  - DRAIN→IDLE after one cycle, pulsing `done`.
- **Beats:**
  - A beat is accepted only in RUN with `ad_valid`=1. Beats in IDLE or DRAIN are ignored.
  - `ad_valid` may drop for any number of cycles. Counters hold while it is low.
- **Stage 1:** registered sum of the N_PE lanes, zero-extended, with a valid bit.
- **Stage 2:** accumulator adds the stage-1 sum.
  - A beat counter runs 0..ACC_LEN-1.
  - On the final beat of a candidate, cand = acc + sum. The accumulator then clears for the next candidate.
- **Comparison:** if cand < `best_sad` (strict), update `best_sad` and the MV to the current candidate. On a tie the earlier candidate is kept.
- **Candidate order:** raster scan, x fastest.
  - x wraps from SR-1 to 0 and increments y.
  - The final candidate is (SR-1, SR-1).
- **Arithmetic:** SAD_W always holds 255*N_PE*ACC_LEN with no overflow. No saturation is needed.
- **Other events:**
  - `start` while busy is ignored.
  - Outputs hold after `done` until the next `start`.
  - Reset mid-search returns to the reset values immediately.

## Timing
- Beat accepted at edge E0.
  - Stage-1 sum registered at E1.
  - Accumulate or compare at E2.
- A candidate's result is visible on `best_*` two edges after its last beat.
- **Start:** `start` sampled at edge S. `busy` is high from S and the first beat is acceptable in the cycle after S.
- **Completion:** final beat at E0.
  - State is DRAIN during the cycle after E0.
  - At E2, `best_*` are final, `done`=1 for exactly one cycle, and `busy`=0.
- **Throughput:** one beat per cycle. Minimum search time is SR*SR*ACC_LEN + 2 cycles after `start`.

## Configuration
- **Macro:** `SAD_MIN_ABORT_EN`.
- **Defined:**
  - Adds input `abort` (1 bit).
  - `abort`=1 in RUN or DRAIN returns the block to IDLE at the next edge.
  - Counters and pipeline are cleared, `busy`=0, `done` is not pulsed, and `best_*` return to their reset values.
  - `abort` in IDLE has no effect.
  - `abort` has priority over a simultaneous final beat.
- **Undefined:** the port does not exist, and a search always runs to `done`.

## Structure
- **Shared package `me_pkg`:** state enum (IDLE/RUN/DRAIN) and the SAD_W/MV_W width functions, used by this block and the PE array.
- **Sub-module `ad_sum_tree`:** N_PE-lane unsigned adder with a registered output and valid. This is stage 1.

## Test plan
All scenarios use N_PE=4, ACC_LEN=2, SR=2 (SAD_W=11, MV_W=1) unless stated otherwise.
- **Ramp:** all lanes = 1 for candidates 0–2, all lanes = 0 for candidate 3 → `best_sad`=0, MV=(1,1), `done` exactly 2 cycles after the last beat.
- **Tie:** candidate SADs 10, 5, 5, 7 → `best_sad`=5, MV=(1,0). The later tie does not replace it.
- **Full scale:** all lanes = 255 for every beat → `best_sad`=2040, MV=(0,0), no overflow.
- **Gaps and ignored inputs:** `ad_valid` toggled 1-0-1 with 3-cycle gaps → same result as the gapless run. `start` during RUN is ignored. Beats in IDLE do not change the outputs.
- **Reset:** `rst_n` asserted mid-candidate → `best_sad`=0x7FF and MV=0 immediately. A new search after reset is correct.
- **Abort (`SAD_MIN_ABORT_EN`):** `abort` after 3 beats → IDLE next cycle, `done` never pulses, outputs at reset values.
